// File: rtl/edge_counter_bank.sv
// Gated multi-channel edge counter. Reports coherent snapshots of every count as packet sweeps.
// Define EDGE_COUNTER_SYNC_EN to put a two-flop synchronizer on each sig bit.
module edge_counter_bank #(
  parameter int CH          = 4,
  parameter int WIDTH       = 16,
  parameter int SEND_PERIOD = 100,
  parameter int EDGE_MODE   = 0,
  localparam int CHW        = (CH > 1) ? $clog2(CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [CH-1:0]    sig,
  input  logic             pkt_ready,
  output logic             pkt_valid,
  output logic [CHW-1:0]   pkt_ch,
  output logic [WIDTH-1:0] pkt_count,
  output logic             pkt_ovf,
  output logic [1:0]       pkt_kind
);
  localparam int TW = $clog2(SEND_PERIOD);
  localparam logic [WIDTH-1:0] CNT_MAX  = '1;
  localparam logic [WIDTH-1:0] CNT_ONE  = WIDTH'(1);
  localparam logic [TW-1:0]    TMR_ONE  = TW'(1);
  localparam logic [TW-1:0]    TMR_LAST = TW'(SEND_PERIOD - 1);
  localparam logic [CHW-1:0]   CH_ONE   = CHW'(1);
  localparam logic [CHW-1:0]   CH_LAST  = CHW'(CH - 1);
  localparam logic [1:0] KIND_CYCLIC = 2'd0;
  localparam logic [1:0] KIND_START  = 2'd1;
  localparam logic [1:0] KIND_FINAL  = 2'd2;

  typedef enum logic {IDLE = 1'b0, SWEEP = 1'b1} state_t;

  // Kind encoding is ordered by priority, so the larger code wins.
  function automatic logic [1:0] max_kind(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  logic [CH-1:0]    sig_s;
  logic [CH-1:0]    sig_q;
  logic [CH-1:0]    edge_s;
  logic             enable_q;
  logic             gate_rise;
  logic             gate_fall;
  logic             wrap_s;
  logic             any_trig;
  logic [1:0]       trig_kind;
  logic [WIDTH-1:0] cnt [CH];
  logic [CH-1:0]    ovf;
  logic [TW-1:0]    timer;
  logic             pend_valid;
  logic [1:0]       pend_kind;
  logic [WIDTH-1:0] snap_cnt [CH];
  logic [CH-1:0]    snap_ovf;
  logic [CHW-1:0]   next_ch;
  state_t           state_q;
  state_t           state_d;
  logic             load_s;
  logic             adv_s;

`ifdef EDGE_COUNTER_SYNC_EN
  logic [CH-1:0] sync1;
  logic [CH-1:0] sync2;

  // Two-flop synchronizer for asynchronous inputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sig;
      sync2 <= sync1;
    end
  end
  assign sig_s = sync2;
`else
  assign sig_s = sig;
`endif

  // Delayed copies of the signals and the gate for edge detection.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sig_q    <= '0;
      enable_q <= 1'b0;
    end else begin
      sig_q    <= sig_s;
      enable_q <= enable;
    end
  end

  // Edge term selected by the compile-time mode.
  always_comb begin
    edge_s = '0;
    case (EDGE_MODE)
      32'sd0:  edge_s = sig_s & ~sig_q;
      32'sd1:  edge_s = ~sig_s & sig_q;
      32'sd2:  edge_s = sig_s ^ sig_q;
      default: edge_s = sig_s & ~sig_q;
    endcase
  end

  assign gate_rise = enable & ~enable_q;
  assign gate_fall = ~enable & enable_q;
  assign wrap_s    = enable & ~gate_rise & (timer == TMR_LAST);
  assign any_trig  = gate_rise | gate_fall | wrap_s;

  // Trigger kind for this cycle; final outranks start outranks cyclic.
  always_comb begin
    trig_kind = KIND_CYCLIC;
    if (gate_fall) begin
      trig_kind = KIND_FINAL;
    end else if (gate_rise) begin
      trig_kind = KIND_START;
    end else begin
      trig_kind = KIND_CYCLIC;
    end
  end

  // Saturating per-channel counters with sticky overflow; an edge at full scale is lost.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) cnt[i] <= '0;
      ovf <= '0;
    end else begin
      for (int i = 0; i < CH; i++) begin
        if (gate_rise) begin
          cnt[i] <= '0;
          ovf[i] <= 1'b0;
        end else if (enable && edge_s[i]) begin
          if (cnt[i] == CNT_MAX) ovf[i] <= 1'b1;
          else                   cnt[i] <= cnt[i] + CNT_ONE;
        end
      end
    end
  end

  // Cyclic report timer, running only inside the gate window.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer <= '0;
    end else if (!enable || gate_rise || wrap_s) begin
      timer <= '0;
    end else begin
      timer <= timer + TMR_ONE;
    end
  end

  // One-deep pending trigger; a trigger in the same cycle as a load survives the load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_valid <= 1'b0;
      pend_kind  <= KIND_CYCLIC;
    end else if (any_trig) begin
      pend_valid <= 1'b1;
      pend_kind  <= (pend_valid && !load_s) ? max_kind(pend_kind, trig_kind) : trig_kind;
    end else if (load_s) begin
      pend_valid <= 1'b0;
    end
  end

  // Sweep state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Sweep next state: load snapshot on entry and on back-to-back restart.
  always_comb begin
    state_d = state_q;
    load_s  = 1'b0;
    adv_s   = 1'b0;
    case (state_q)
      IDLE: begin
        if (pend_valid) begin
          state_d = SWEEP;
          load_s  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      SWEEP: begin
        if (!pkt_ready) begin
          state_d = SWEEP;
        end else if (pkt_ch != CH_LAST) begin
          adv_s = 1'b1;
        end else if (pend_valid) begin
          load_s = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign next_ch   = pkt_ch + CH_ONE;
  assign pkt_valid = (state_q == SWEEP);

  // Snapshot and registered packet fields.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < CH; i++) snap_cnt[i] <= '0;
      snap_ovf  <= '0;
      pkt_ch    <= '0;
      pkt_count <= '0;
      pkt_ovf   <= 1'b0;
      pkt_kind  <= KIND_CYCLIC;
    end else if (load_s) begin
      snap_cnt  <= cnt;
      snap_ovf  <= ovf;
      pkt_ch    <= '0;
      pkt_count <= cnt[0];
      pkt_ovf   <= ovf[0];
      pkt_kind  <= pend_kind;
    end else if (adv_s) begin
      pkt_ch    <= next_ch;
      pkt_count <= snap_cnt[next_ch];
      pkt_ovf   <= snap_ovf[next_ch];
    end
  end
endmodule
